// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and counter sizing.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter wide enough to index bits 0..width-1, never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/full_adder.sv
// One-bit full adder used as the serial datapath slice.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one bit per clock through a single full adder,
// with a registered carry and a two-state IDLE/ADD controller.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int             CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             finish;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] psum;
  logic [WIDTH-1:0] psum_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // New sum bit enters at the MSB so that after WIDTH steps bit 0 sits at the LSB.
  if (WIDTH == 1) begin : g_one
    assign psum_nxt = fa_sum;
  end else begin : g_wide
    assign psum_nxt = {fa_sum, psum[WIDTH-1:1]};
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ADD;
          load      = 1'b1;
        end
      end
      ADD: begin
        step = 1'b1;
        if (cnt == LAST) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      psum  <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        a_sh  <= a;
        b_sh  <= b;
        psum  <= '0;
        cnt   <= '0;
        carry <= 1'b0;
      end else if (step) begin
        a_sh  <= a_sh >> 1;
        b_sh  <= b_sh >> 1;
        psum  <= psum_nxt;
        cnt   <= cnt + CNT_W'(1);
        carry <= fa_cout;
      end
      // Visible result only moves on the completion edge.
      if (finish) begin
        sum  <= psum_nxt;
        cout <= fa_cout;
      end
    end
  end

  assign busy = (state == ADD);

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder at WIDTH=8.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int errors = 0;
  int checks = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a start for one cycle; returns just after the accepting edge.
  task automatic launch(input logic [W-1:0] va, input logic [W-1:0] vb);
    a     = va;
    b     = vb;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done; n = ticks since acceptance, or -1 on timeout.
  task automatic wait_done(output int n);
    n = -1;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        n = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++;
    if (sum !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", sum); end
    checks++;
    if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", cout); end
  endtask

  task automatic test_carry_chain();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_at = -1;
    int held_bad = 0;
    launch(8'hFF, 8'h01);
    for (int k = 0; k < 12; k++) begin
      if (busy) begin
        busy_cnt++;
        if (sum !== 8'h00 || cout !== 1'b0) held_bad++;
      end
      if (done) begin
        done_cnt++;
        done_at = k;
        checks++;
        if (sum !== 8'h00 || cout !== 1'b1) begin
          errors++; $display("FAIL carry_result: got %h/%b want 00/1", sum, cout);
        end
      end
      tick();
    end
    checks++;
    if (busy_cnt != 8) begin errors++; $display("FAIL carry_busy_len: got %0d want 8", busy_cnt); end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL carry_done_count: got %0d want 1", done_cnt); end
    checks++;
    if (done_at != 8) begin errors++; $display("FAIL carry_latency: got %0d want 8", done_at); end
    checks++;
    if (held_bad != 0) begin errors++; $display("FAIL carry_sum_held: got %0d early changes want 0", held_bad); end
    checks++;
    if (sum !== 8'h00 || cout !== 1'b1) begin
      errors++; $display("FAIL carry_hold_after: got %h/%b want 00/1", sum, cout);
    end
  endtask

  task automatic test_captured_operands();
    int n;
    launch(8'hA5, 8'h5A);
    a = 8'h00;
    b = 8'h00;
    wait_done(n);
    checks++;
    if (n != 8) begin errors++; $display("FAIL capture_latency: got %0d want 8", n); end
    checks++;
    if (sum !== 8'hFF || cout !== 1'b0) begin
      errors++; $display("FAIL capture_result: got %h/%b want ff/0", sum, cout);
    end
    tick();
  endtask

  task automatic test_ignore_start();
    int done_cnt = 0;
    int done_at = -1;
    a = 8'h80; b = 8'h80; start = 1'b1;
    tick();
    for (int k = 1; k < 16; k++) begin
      if (k == 3) begin
        a = 8'h01; b = 8'h01; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        done_cnt++;
        done_at = k;
        checks++;
        if (sum !== 8'h00 || cout !== 1'b1) begin
          errors++; $display("FAIL ignore_result: got %h/%b want 00/1", sum, cout);
        end
      end
    end
    checks++;
    if (done_cnt != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
    checks++;
    if (done_at != 8) begin errors++; $display("FAIL ignore_latency: got %0d want 8", done_at); end
  endtask

  task automatic test_reset_abort();
    int done_cnt = 0;
    int n;
    launch(8'h7F, 8'h7F);
    repeat (4) tick();
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_ctrl: got busy=%b done=%b want 0/0", busy, done);
    end
    checks++;
    if (sum !== 8'h00 || cout !== 1'b0) begin
      errors++; $display("FAIL abort_result: got %h/%b want 00/0", sum, cout);
    end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done) done_cnt++;
      tick();
    end
    checks++;
    if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt); end
    launch(8'h12, 8'h34);
    wait_done(n);
    checks++;
    if (n != 8) begin errors++; $display("FAIL post_reset_latency: got %0d want 8", n); end
    checks++;
    if (sum !== 8'h46 || cout !== 1'b0) begin
      errors++; $display("FAIL post_reset_result: got %h/%b want 46/0", sum, cout);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    launch(8'h0F, 8'h01);
    wait_done(n);
    checks++;
    if (n != 8) begin errors++; $display("FAIL b2b_first_latency: got %0d want 8", n); end
    checks++;
    if (sum !== 8'h10 || cout !== 1'b0) begin
      errors++; $display("FAIL b2b_first_result: got %h/%b want 10/0", sum, cout);
    end
    launch(8'hF0, 8'h10);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    wait_done(n);
    checks++;
    if (n != 8) begin errors++; $display("FAIL b2b_second_latency: got %0d want 8", n); end
    checks++;
    if (sum !== 8'h00 || cout !== 1'b1) begin
      errors++; $display("FAIL b2b_second_result: got %h/%b want 00/1", sum, cout);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width: got done=%b want 0", done); end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_captured_operands();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and sum width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to add a and b, sampled on the rising edge of clk.
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand, captured when start is accepted.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand, captured when start is accepted.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an addition is in progress.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse that marks a completed result.
REQ-009 The block SHALL have port sum, output, WIDTH bits: the result of a + b modulo 2^WIDTH.
REQ-010 The block SHALL have port cout, output, 1 bit: the carry out of the most significant bit.

Function
REQ-011 The block SHALL add LSB-first, one bit per clock, through a single 1-bit full-adder datapath with a registered carry.
REQ-012 The FSM SHALL have two states, IDLE and ADD.
REQ-013 IDLE -> ADD transition: on a clock edge where start=1. At that edge, a and b load into shift registers, the carry clears, the bit counter clears, and busy becomes 1.
REQ-014 In ADD, each edge SHALL:
- add the current LSBs and the carry;
- shift the resulting sum bit into the MSB of the partial-sum register;
- shift both operand registers right;
- increment the counter.
REQ-015 ADD -> IDLE transition: on the edge that processes bit WIDTH-1 (the WIDTH-th ADD edge). At that edge:
- sum loads the complete result;
- cout loads the final carry;
- done becomes 1 and busy becomes 0.
REQ-016 Latency: done SHALL be high exactly WIDTH cycles after the edge that accepted start, and SHALL stay high for exactly one cycle.
REQ-017 sum and cout SHALL hold their last result, and SHALL change only at the completion edge.
REQ-018 When start=1 while in ADD, the block SHALL ignore it: operands unchanged and no restart.
REQ-019 When start=1 in the cycle done=1, the block SHALL accept it, because the FSM is already in IDLE. This gives back-to-back operation with a throughput of one result per WIDTH+1 cycles.
REQ-020 Changes on a and b after acceptance SHALL NOT affect the result in progress.
REQ-021 With WIDTH=1, done SHALL pulse on the edge after acceptance, with sum=a^b and cout=a&b.

Reset
REQ-022 While rst=1, the block SHALL immediately (asynchronously) force:
- the state to IDLE;
- busy, done and cout to 0;
- sum and all shift registers, the counter and the carry to 0.
REQ-023 A reset asserted mid-addition SHALL abort the addition with no done pulse. The first start accepted after rst deasserts SHALL behave per REQ-013.

Structure
REQ-024 A shared package serial_adder_pkg SHALL hold the state encoding (IDLE=0, ADD=1) and the counter-width constant $clog2(WIDTH) rounded up to at least 1.
REQ-025 The bit datapath SHALL be a separate sub-module full_adder (inputs a, b, cin; outputs sum, cout), instantiated once.
REQ-026 All state SHALL be held in flops clocked by clk and reset by rst; there SHALL be no latches and no gated clocks.

Verification (WIDTH=8)
REQ-027 The bench SHALL apply rst for 2 cycles and then release it, and SHALL check busy=0, done=0, sum=0x00, cout=0.
REQ-028 The bench SHALL apply start with a=0xFF, b=0x01, and SHALL check that busy is high for 8 cycles, done pulses once 8 cycles after acceptance, sum=0x00 and cout=1.
REQ-029 The bench SHALL apply start with a=0xA5, b=0x5A, then change a/b to 0x00 on the next cycle, and SHALL check sum=0xFF and cout=0 (the captured operands are used).
REQ-030 The bench SHALL start with a=0x80, b=0x80, pulse start with a=0x01, b=0x01 at cycle 3, and SHALL check that the result is sum=0x00, cout=1 and that only one done pulse occurs.
REQ-031 The bench SHALL start with a=0x7F, b=0x7F and assert rst at cycle 4, and SHALL check that busy=0, there is no done pulse, and sum=0x00; it SHALL then start with a=0x12, b=0x34 and check sum=0x46, cout=0.
REQ-032 The bench SHALL hold start high in the done cycle after a=0x0F+b=0x01, with next operands a=0xF0, b=0x10. It SHALL check:
- the first done shows sum=0x10;
- the second done occurs 8 cycles later and shows sum=0x00, cout=1.
